mh_arbiter: RTL and testbench
=============================

Name: mh_arbiter

Overview:
- Shares one miss handler between NUM_CLIENTS cache instances, e.g. separate caches for the traversal and intersection units.
- Requests are arbitrated round-robin and registered onto the single miss-handler request port.
- The miss handler returns data strictly in request order, so the arbiter keeps a FIFO of client IDs. It uses that FIFO to route each response back to the client that issued the request.
- Sits between the caches' to_mh/from_mh ports and the miss handler.

Parameters:
- NUM_CLIENTS, 4: number of requesting caches; range 2..8.
- ADDR_W, 32: miss-handler address width.
- RDATA_W, 64: miss-handler read data width.
- ID_DEPTH, 16: ID FIFO depth, which is the maximum number of outstanding requests; power of 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- cl_addr  in  NUM_CLIENTS*ADDR_W  per-client request address; client i occupies bits [i*ADDR_W +: ADDR_W].
- cl_valid  in  NUM_CLIENTS  per-client request valid.
- cl_stall  out  NUM_CLIENTS  per-client request stall.
- cl_rdata  out  RDATA_W  response data, broadcast to all clients.
- cl_rvalid  out  NUM_CLIENTS  per-client response valid; one-hot or zero.
- cl_rstall  in  NUM_CLIENTS  per-client response stall.
- mh_addr  out  ADDR_W  request address to the miss handler.
- mh_valid  out  1  request valid to the miss handler.
- mh_stall  in  1  miss-handler request stall.
- mh_rdata  in  RDATA_W  response data from the miss handler.
- mh_rvalid  in  1  response valid from the miss handler.
- mh_rstall  out  1  response stall to the miss handler.
- outstanding  out  $clog2(ID_DEPTH)+1  current ID FIFO occupancy.
- err_orphan  out  1  sticky: a response arrived while no request was outstanding.

Behaviour:
- Handshake on every interface: a transfer occurs on the cycle where valid & ~stall. A source holds valid and its data stable while stalled.
- Reset (rst==0 at posedge clk):
  - mh_valid=0, mh_addr=0, rr_ptr=0, ID FIFO empty, outstanding=0, err_orphan=0.
  - While rst==0, no grant is issued, so cl_stall=cl_valid. mh_rstall=0.
- Acceptance condition: accept = (~mh_valid | ~mh_stall) & (outstanding != ID_DEPTH) & rst.
  - Full blocks acceptance even if a pop happens in the same cycle. No bypass.
- Arbitration (combinational): when accept, scan clients starting at rr_ptr and wrapping modulo NUM_CLIENTS. The first i with cl_valid[i] is granted (grant[i]=1).
- cl_stall[i] = cl_valid[i] & ~grant[i].
- On a grant to k, at the next posedge:
  - mh_addr <= cl_addr[k], mh_valid <= 1.
  - Push k into the ID FIFO.
  - rr_ptr <= (k+1) mod NUM_CLIENTS.
- No grant: rr_ptr is unchanged. If mh_valid & ~mh_stall, then mh_valid <= 0.
- Request latency is exactly 1 cycle from client acceptance to mh_valid.
- Response routing (combinational, 0 latency):
  - head = FIFO head ID.
  - cl_rdata = mh_rdata.
  - cl_rvalid[head] = mh_rvalid & ~empty; all other bits are 0.
  - mh_rstall = mh_rvalid & ~empty & cl_rstall[head].
- Pop the FIFO when mh_rvalid & ~empty & ~cl_rstall[head].
- A simultaneous push and pop leaves outstanding unchanged; head and tail pointers both advance and wrap modulo ID_DEPTH.
- Orphan response (mh_rvalid while FIFO empty): no cl_rvalid is asserted, mh_rstall=0 so the data is consumed and dropped, and err_orphan <= 1 (sticky until reset).
- Reset mid-operation: all state is cleared. Responses still in flight afterwards are handled as orphans. The miss handler is reset together with this block.
- The arbiter does not reorder requests. The miss handler must return responses in order, one per request.

Test Plan:
- Single client 0 issues addr 0x100 with mh_stall=0 → mh_valid=1 with mh_addr=0x100 one cycle later; outstanding=1. The response 0xDEAD asserts cl_rvalid=4'b0001 with cl_rdata=0xDEAD in the same cycle; outstanding returns to 0.
- Clients 0–3 all valid continuously from reset, addrs 0x10/0x20/0x30/0x40 → grants in order 0,1,2,3,0 on consecutive cycles. Responses returned in order are routed to cl_rvalid 0001, 0010, 0100, 1000.
- mh_stall held at 1 for 5 cycles with mh_valid=1 → mh_addr is stable, every cl_stall bit with cl_valid set is 1, and no FIFO push occurs. After release, the next grant follows rr_ptr.
- 16 requests issued with no responses → outstanding=16 and all requesters are stalled. One response pops the FIFO; the next accept happens the following cycle, never the same cycle.
- Response for client 2 with cl_rstall[2]=1 for 3 cycles → mh_rstall=1 for those cycles and the FIFO is not popped. On release: one pop, outstanding decrements by 1.
- mh_rvalid=1 with the FIFO empty → cl_rvalid=0, mh_rstall=0, err_orphan=1 on the next cycle. Asserting rst=0 with 3 requests outstanding gives outstanding=0, mh_valid=0 and err_orphan=0 on the next cycle.

Source files
------------

// File: rtl/mh_arbiter.sv
// mh_arbiter: round-robin front end that shares one miss handler between
// NUM_CLIENTS caches. Winning requests are registered onto the miss-handler
// request port. The client ID of each accepted request is queued, and the
// in-order responses are routed back to their clients from that queue.

// Per-client slice: request stall and response steering for one client.
module mh_arbiter_client #(
  parameter int CW  = 2,
  parameter int IDX = 0
) (
  input  logic          valid,
  input  logic          grant,
  input  logic          rsp_ok,
  input  logic [CW-1:0] head,
  input  logic          rstall_in,
  output logic          stall,
  output logic          rvalid,
  output logic          rstall_out
);
  logic sel;

  // This client owns the current response when it is the FIFO head.
  assign sel        = rsp_ok & (head == CW'(IDX));
  assign stall      = valid & ~grant;
  assign rvalid     = sel;
  assign rstall_out = sel & rstall_in;
endmodule

module mh_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = 32,
  parameter int RDATA_W     = 64,
  parameter int ID_DEPTH    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
  input  logic [NUM_CLIENTS-1:0]        cl_valid,
  output logic [NUM_CLIENTS-1:0]        cl_stall,
  output logic [RDATA_W-1:0]            cl_rdata,
  output logic [NUM_CLIENTS-1:0]        cl_rvalid,
  input  logic [NUM_CLIENTS-1:0]        cl_rstall,
  output logic [ADDR_W-1:0]             mh_addr,
  output logic                          mh_valid,
  input  logic                          mh_stall,
  input  logic [RDATA_W-1:0]            mh_rdata,
  input  logic                          mh_rvalid,
  output logic                          mh_rstall,
  output logic [$clog2(ID_DEPTH):0]     outstanding,
  output logic                          err_orphan
);
  localparam int CW = $clog2(NUM_CLIENTS);
  localparam int PW = $clog2(ID_DEPTH);

  logic [NUM_CLIENTS-1:0][ADDR_W-1:0] addr_v;
  logic [CW-1:0]          rr_ptr;
  logic [CW-1:0]          gnt_id;
  logic [CW-1:0]          scan_id;
  logic                   gnt_any;
  logic [NUM_CLIENTS-1:0] grant;
  logic                   accept;

  logic [CW-1:0]          id_mem [ID_DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [PW:0]            count;
  logic                   empty;
  logic                   full;
  logic [CW-1:0]          head;
  logic                   rsp_ok;
  logic                   push;
  logic                   pop;
  logic [NUM_CLIENTS-1:0] rstall_sel;

  assign addr_v = cl_addr;

  // Full is judged on the registered count: a same-cycle pop never frees a slot.
  assign empty  = (count == '0);
  assign full   = (count == (PW+1)'(ID_DEPTH));
  assign accept = (~mh_valid | ~mh_stall) & ~full & rst;

  // Round-robin scan from rr_ptr; walking offsets high-to-low lets the
  // lowest offset (closest to rr_ptr) be the last, winning assignment.
  always_comb begin
    gnt_id  = '0;
    gnt_any = 1'b0;
    scan_id = '0;
    grant   = '0;
    if (accept) begin
      for (int off = NUM_CLIENTS - 1; off >= 0; off--) begin
        scan_id = CW'((int'(rr_ptr) + off) % NUM_CLIENTS);
        if (cl_valid[scan_id]) begin
          gnt_id  = scan_id;
          gnt_any = 1'b1;
        end
      end
    end
    if (gnt_any) grant[gnt_id] = 1'b1;
  end

  assign push = gnt_any;

  // Response side: the head ID selects the destination; data is broadcast.
  assign head      = id_mem[rd_ptr];
  assign rsp_ok    = rst & mh_rvalid & ~empty;
  assign cl_rdata  = mh_rdata;
  assign mh_rstall = |rstall_sel;
  assign pop       = rsp_ok & ~mh_rstall;

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_cl
    mh_arbiter_client #(.CW(CW), .IDX(g)) u_cl (
      .valid      (cl_valid[g]),
      .grant      (grant[g]),
      .rsp_ok     (rsp_ok),
      .head       (head),
      .rstall_in  (cl_rstall[g]),
      .stall      (cl_stall[g]),
      .rvalid     (cl_rvalid[g]),
      .rstall_out (rstall_sel[g])
    );
  end

  // ID storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr] <= gnt_id;
  end

  // ID FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Request register toward the miss handler and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mh_valid <= 1'b0;
      mh_addr  <= '0;
      rr_ptr   <= '0;
    end else if (push) begin
      mh_valid <= 1'b1;
      mh_addr  <= addr_v[gnt_id];
      rr_ptr   <= (gnt_id == CW'(NUM_CLIENTS - 1)) ? '0 : gnt_id + CW'(1);
    end else if (mh_valid && !mh_stall) begin
      mh_valid <= 1'b0;
    end
  end

  // A response with nothing outstanding is consumed and flagged until reset.
  always_ff @(posedge clk) begin
    if (!rst)                    err_orphan <= 1'b0;
    else if (mh_rvalid && empty) err_orphan <= 1'b1;
  end

  assign outstanding = count;
endmodule

// File: tb/tb_mh_arbiter.sv
// Randomized bench for mh_arbiter: queue-based reference model plus a
// scoreboard monitor that checks requests and responses as the DUT emits them.
module tb_mh_arbiter;
  localparam int N     = 4;
  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int DEPTH = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0][AW-1:0] cl_addr_v;
  logic [N-1:0]         cl_valid, cl_stall, cl_rvalid, cl_rstall;
  logic [DW-1:0]        cl_rdata, mh_rdata;
  logic [AW-1:0]        mh_addr;
  logic                 mh_valid, mh_stall, mh_rvalid, mh_rstall, err_orphan;
  logic [4:0]           outstanding;

  always #5 clk = ~clk;

  mh_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .RDATA_W(DW), .ID_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cl_addr(cl_addr_v), .cl_valid(cl_valid),
    .cl_stall(cl_stall), .cl_rdata(cl_rdata), .cl_rvalid(cl_rvalid),
    .cl_rstall(cl_rstall), .mh_addr(mh_addr), .mh_valid(mh_valid),
    .mh_stall(mh_stall), .mh_rdata(mh_rdata), .mh_rvalid(mh_rvalid),
    .mh_rstall(mh_rstall), .outstanding(outstanding), .err_orphan(err_orphan)
  );

  typedef struct { int cl; logic [DW-1:0] data; } rsp_t;

  // Reference model state
  logic [AW-1:0] req_q[$];
  rsp_t          rsp_q[$];
  int            inflight[$];
  int            rr = 0;
  int            mh_pend = 0;
  bit            exp_mhv = 0, exp_orphan = 0, rsp_hold = 0;
  int            exp_win = -1;
  logic [N-1:0]  exp_grant = '0, exp_rv = '0, granted = '0;
  bit            exp_rst = 0;

  // Stimulus knobs
  int p_req = 0, p_mhstall = 0, p_rsp = 0, p_rstall = 0;
  bit fixed_addr = 0, orphan_pulse = 0, rst_req = 0, mon_en = 0;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs; clients and the miss handler hold while not yet accepted.
  task automatic drive();
    rst = rst_req;
    for (int i = 0; i < N; i++) begin
      if (!cl_valid[i] || granted[i]) begin
        if ($urandom_range(99) < p_req) begin
          cl_valid[i]  = 1'b1;
          cl_addr_v[i] = fixed_addr ? AW'((i + 1) * 16) : $urandom;
        end else begin
          cl_valid[i] = 1'b0;
        end
      end
    end
    granted  = '0;
    mh_stall = ($urandom_range(99) < p_mhstall);
    for (int i = 0; i < N; i++) cl_rstall[i] = ($urandom_range(99) < p_rstall);
    if (!rst) begin
      mh_rvalid = 1'b0;
    end else if (!rsp_hold) begin
      if (orphan_pulse && inflight.size() == 0) begin
        mh_rvalid = 1'b1;
        mh_rdata  = {$urandom, $urandom};
      end else if (mh_pend > 0 && $urandom_range(99) < p_rsp) begin
        mh_rvalid = 1'b1;
        mh_rdata  = {$urandom, $urandom};
      end else begin
        mh_rvalid = 1'b0;
      end
    end
  endtask

  // Expected combinational view for this cycle, from the model's own state.
  task automatic eval_model();
    exp_win = -1; exp_grant = '0; exp_rv = '0; exp_rst = 0;
    if (rst && (!exp_mhv || !mh_stall) && inflight.size() < DEPTH)
      for (int off = 0; off < N; off++) begin
        int c = (rr + off) % N;
        if (exp_win < 0 && cl_valid[c]) exp_win = c;
      end
    if (exp_win >= 0) exp_grant[exp_win] = 1'b1;
    if (rst && mh_rvalid && inflight.size() > 0) begin
      exp_rv[inflight[0]] = 1'b1;
      exp_rst = cl_rstall[inflight[0]];
      if (!rsp_hold) rsp_q.push_back('{inflight[0], mh_rdata});
    end
  endtask

  // Advance the model at the clock edge.
  task automatic commit();
    bit mh_xfer, consumed, pop;
    int dummy;
    if (!rst) begin
      rr = 0; exp_mhv = 0; exp_orphan = 0; mh_pend = 0; rsp_hold = 0;
      inflight.delete(); req_q.delete(); rsp_q.delete(); granted = '0;
      return;
    end
    mh_xfer = exp_mhv && !mh_stall;
    consumed = 0; pop = 0;
    if (mh_rvalid) begin
      if (inflight.size() == 0) begin exp_orphan = 1; consumed = 1; end
      else if (!cl_rstall[inflight[0]]) begin pop = 1; consumed = 1; end
    end
    if (mh_xfer) mh_pend++;
    if (pop) begin dummy = inflight.pop_front(); mh_pend--; end
    if (exp_win >= 0) begin
      inflight.push_back(exp_win);
      req_q.push_back(cl_addr_v[exp_win]);
      rr = (exp_win + 1) % N;
      exp_mhv = 1;
      granted[exp_win] = 1'b1;
    end else if (mh_xfer) begin
      exp_mhv = 0;
    end
    rsp_hold = mh_rvalid && !consumed;
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    eval_model();
    @(posedge clk);
    commit();
  endtask

  task automatic run(input int n, input int pr, input int pms, input int prs, input int prst);
    p_req = pr; p_mhstall = pms; p_rsp = prs; p_rstall = prst;
    repeat (n) cycle();
  endtask

  // Monitor: per-cycle output checks plus scoreboard pops on transfers.
  initial begin
    rsp_t         r;
    logic [N-1:0] oh;
    wait (mon_en);
    forever begin
      @(negedge clk);
      #3;
      chk("cl_stall",    cl_stall,    cl_valid & ~exp_grant);
      chk("mh_valid",    mh_valid,    exp_mhv);
      chk("outstanding", outstanding, inflight.size());
      chk("err_orphan",  err_orphan,  exp_orphan);
      chk("mh_rstall",   mh_rstall,   exp_rst);
      chk("cl_rvalid",   cl_rvalid,   exp_rv);
      if (mh_valid && !mh_stall) begin
        if (req_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL mh_req: got addr %0h, expected no request", mh_addr);
        end else begin
          chk("mh_addr", mh_addr, req_q.pop_front());
        end
      end
      if ((cl_rvalid & ~cl_rstall) != '0) begin
        if (rsp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL cl_rsp: got rvalid %0b, expected no response", cl_rvalid);
        end else begin
          r = rsp_q.pop_front();
          oh = '0; oh[r.cl] = 1'b1;
          chk("rsp_client", cl_rvalid, oh);
          chk("cl_rdata",   cl_rdata,  r.data);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; cl_valid = '0; cl_addr_v = '0; mh_stall = 1'b0;
    mh_rvalid = 1'b0; mh_rdata = '0; cl_rstall = '0;
    rst_req = 0;
    run(2, 50, 0, 0, 0);
    mon_en = 1;
    run(2, 50, 0, 0, 0);                       // reset state, cl_stall = cl_valid
    rst_req = 1; fixed_addr = 1;
    run(8, 100, 0, 0, 0);                      // all clients valid: strict rotation
    fixed_addr = 0;
    run(300, 60, 30, 50, 30);                  // mixed random traffic
    run(30, 100, 0, 0, 0);                     // no responses: fill to capacity
    #1 chk("full_outstanding", outstanding, DEPTH);
    chk("full_stall", cl_stall, cl_valid);
    run(10, 100, 0, 100, 0);                   // pops free slots one cycle later
    run(100, 70, 90, 50, 20);                  // heavy request stall
    run(100, 70, 20, 60, 80);                  // heavy response stall
    run(60, 0, 0, 100, 0);                     // drain
    #1 chk("drain_outstanding", outstanding, 0);
    orphan_pulse = 1;
    run(1, 0, 0, 0, 0);
    orphan_pulse = 0;
    #1 chk("orphan_flag", err_orphan, 1);
    run(4, 100, 0, 0, 0);                      // build up outstanding requests
    rst_req = 0;
    run(1, 100, 0, 0, 0);
    #1 chk("rst_outstanding", outstanding, 0);
    chk("rst_mh_valid", mh_valid, 0);
    chk("rst_err_orphan", err_orphan, 0);
    rst_req = 1;
    run(200, 60, 30, 50, 30);
    run(60, 0, 0, 100, 0);
    #1 chk("end_req_q_left", req_q.size(), 0);
    chk("end_rsp_q_left", rsp_q.size(), 0);
    chk("end_outstanding", outstanding, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
